// File: rtl/product_accumulator_128_pkg.sv
// ---------------------------------------------------------------------------
// product_accumulator_128_pkg
// Shared definitions for the product accumulator:
//   - default widths (product, job length / beat counter, accumulator)
//   - FSM state encoding used by the top module
// Optional build macro used elsewhere in this slice: PRODUCT_ACC_SATURATE_EN
// ---------------------------------------------------------------------------
package product_accumulator_128_pkg;

    localparam int PROD_W_DEF = 128;
    localparam int LEN_W_DEF  = 16;
    // PROD_W + LEN_W bits can hold the sum of 2^LEN_W-1 full-scale products.
    localparam int ACC_W_DEF  = PROD_W_DEF + LEN_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/product_accumulator_128_acc_sat_adder.sv
// ---------------------------------------------------------------------------
// product_accumulator_128_acc_sat_adder
// Combinational adder: acc + zero-extended product, with carry-out.
// When PRODUCT_ACC_SATURATE_EN is defined the sum clamps to all ones on
// carry-out; otherwise it wraps modulo 2^ACC_W.
// Ports:
//   acc      in   ACC_W   current accumulator value
//   product  in   PROD_W  unsigned product to add
//   sum      out  ACC_W   new accumulator value (wrapped or clamped)
//   carry    out  1       carry out of bit ACC_W-1
// ---------------------------------------------------------------------------
module product_accumulator_128_acc_sat_adder
    import product_accumulator_128_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W-1:0] product_ext;
    logic [ACC_W:0]   raw_sum;

    generate
        if (ACC_W < PROD_W) begin : g_bad_width
            $error("ACC_W must be >= PROD_W");
        end else if (ACC_W > PROD_W) begin : g_ext
            assign product_ext = {{(ACC_W-PROD_W){1'b0}}, product};
        end else begin : g_same
            assign product_ext = product;
        end
    endgenerate

    assign raw_sum = {1'b0, acc} + {1'b0, product_ext};
    assign carry   = raw_sum[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, acc is all ones, so any further non-zero add carries
    // again and the value stays pinned at all ones.
    assign sum = carry ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
    assign sum = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator_128.sv
// ---------------------------------------------------------------------------
// product_accumulator_128
// Sums a programmed number of unsigned products into a wide accumulator and
// presents one result per job with a beat count and sticky overflow flag.
// Build option: PRODUCT_ACC_SATURATE_EN (clamp accumulator on carry-out).
// Ports:
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset
//   start         in   1       job start, honoured only in IDLE
//   len           in   LEN_W   number of products in the job (sampled with start)
//   busy          out  1       state != IDLE
//   in_valid      in   1       product beat valid
//   in_ready      out  1       product accepted (ACCUM state)
//   in_product    in   PROD_W  unsigned product
//   out_valid     out  1       result available (DONE state)
//   out_ready     in   1       consumer takes the result
//   out_sum       out  ACC_W   accumulated sum (registered)
//   out_count     out  LEN_W   products accepted in this job (registered)
//   out_overflow  out  1       sticky carry-out flag (registered)
// ---------------------------------------------------------------------------
module product_accumulator_128
    import product_accumulator_128_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_count,
    output logic              out_overflow
);

    acc_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    product_accumulator_128_acc_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc     (acc_reg),
        .product (in_product),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            remaining_reg <= remaining_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        remaining_next = remaining_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next       = '0;
                    count_next     = '0;
                    overflow_next  = 1'b0;
                    remaining_next = len;
                    // An empty job goes straight to DONE with sum 0, count 0.
                    state_next     = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone is a beat.
                if (in_valid) begin
                    acc_next       = add_sum;
                    overflow_next  = overflow_reg | add_carry;
                    count_next     = count_reg + LEN_W'(1);
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // start here is deliberately ignored, even with the handshake.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign in_ready     = (state_reg == ACCUM);
    assign out_valid    = (state_reg == DONE);
    assign out_sum      = acc_reg;
    assign out_count    = count_reg;
    assign out_overflow = overflow_reg;

endmodule
